// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC calendar core.
//   - FLD_* : field selectors used on the field-write interface
//   - BCD_* : BCD limit constants used by the carry chain and presentation
//   - BCD helper functions (increment, conversion, leap-year test)
package rtc_pkg;

    localparam logic [2:0] FLD_SEC   = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_HOUR  = 3'd2;
    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;
    localparam logic [2:0] FLD_WDAY  = 3'd6;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_12 = 8'h12;

    // Two BCD digits to binary (valid for 00..99).
    function automatic logic [7:0] bcd2bin8(input logic [7:0] b);
        return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
    endfunction

    // Binary 0..99 to two BCD digits.
    function automatic logic [7:0] bin2bcd8(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Two-digit BCD +1 (caller handles the wrap value).
    function automatic logic [7:0] bcd_inc8(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

    // Four-digit BCD +1; 9999 rolls naturally to 0000.
    function automatic logic [15:0] bcd_inc16(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every nibble is a legal decimal digit.
    function automatic logic nibbles_ok(input logic [15:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) &&
               (d[11:8] <= 4'd9) && (d[15:12] <= 4'd9);
    endfunction

    // Gregorian leap year on a BCD year. The century test reduces to
    // "low two digits are 00", so divisibility by 4 is checked on the low
    // pair, or on the high pair for century years (covers /400; 0000 is leap).
    function automatic logic is_leap(input logic [15:0] y);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = bcd2bin8(y[7:0]);
        hi = bcd2bin8(y[15:8]);
        if (lo != 8'd0) return (lo[1:0] == 2'd0);
        return (hi[1:0] == 2'd0);
    endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// rtc_calendar_core_if: host-side bundle of the RTC core.
//   Controls : run, hour_mode
//   Set path : set_valid, set_field, set_data -> set_err
//   Alarms   : alm_wr, alm_idx, alm_data, alm_ack -> alm_pending
//   Time     : tick_1hz, sec/min/hour_bcd, pm, day/month/year_bcd, weekday
// Handshake: set_valid and alm_wr are single-cycle requests sampled on the
// rising clock edge; the core is always ready, so there is no ready signal
// and a request held high for N cycles is N separate writes. set_err is the
// registered reject response, high for exactly the cycle after a bad write.
interface rtc_calendar_core_if #(
    parameter int NUM_ALARMS = 4
);
    logic                  run;
    logic                  hour_mode;
    logic                  set_valid;
    logic [2:0]            set_field;
    logic [15:0]           set_data;
    logic                  set_err;
    logic                  alm_wr;
    logic [2:0]            alm_idx;
    logic [16:0]           alm_data;
    logic [NUM_ALARMS-1:0] alm_ack;
    logic [NUM_ALARMS-1:0] alm_pending;
    logic                  tick_1hz;
    logic [7:0]            sec_bcd;
    logic [7:0]            min_bcd;
    logic [7:0]            hour_bcd;
    logic                  pm;
    logic [7:0]            day_bcd;
    logic [7:0]            month_bcd;
    logic [15:0]           year_bcd;
    logic [2:0]            weekday;

    modport master (
        output run, hour_mode, set_valid, set_field, set_data,
               alm_wr, alm_idx, alm_data, alm_ack,
        input  set_err, alm_pending, tick_1hz, sec_bcd, min_bcd, hour_bcd,
               pm, day_bcd, month_bcd, year_bcd, weekday
    );

    modport slave (
        input  run, hour_mode, set_valid, set_field, set_data,
               alm_wr, alm_idx, alm_data, alm_ack,
        output set_err, alm_pending, tick_1hz, sec_bcd, min_bcd, hour_bcd,
               pm, day_bcd, month_bcd, year_bcd, weekday
    );
endinterface

// File: rtl/rtc_days_in_month.sv
// rtc_days_in_month: last valid day (BCD) of a BCD month.
//   month_bcd_i : month 01..12 in BCD
//   leap_i      : 1 when the year in question is a leap year
//   last_day_o  : 28/29/30/31 in BCD (31 for an out-of-range month)
module rtc_days_in_month
    import rtc_pkg::*;
(
    input  logic [7:0] month_bcd_i,
    input  logic       leap_i,
    output logic [7:0] last_day_o
);
    always_comb begin
        last_day_o = 8'h31;
        case (month_bcd_i)
            8'h02:                      last_day_o = leap_i ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: last_day_o = 8'h30;
            default:                    last_day_o = 8'h31;
        endcase
    end
endmodule

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: single-clock BCD time/date keeper with prescaler,
// validated field writes, 12/24 h presentation and hh:mm alarm channels.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : rtc_calendar_core_if.slave (controls, set path, alarms, time)
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int          CLK_DIV       = 100000000,
    parameter int          NUM_ALARMS    = 4,
    parameter logic [15:0] RESET_YEAR    = 16'h2000,
    parameter logic [2:0]  RESET_WEEKDAY = 3'd6
) (
    input logic CLK,
    input logic RST,
    rtc_calendar_core_if.slave bus
);
    localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]    day_q, day_d, month_q, month_d;
    logic [15:0]   year_q, year_d;
    logic [2:0]    wday_q, wday_d;
    logic          set_err_q, set_err_d, tick_q, tick_d;

    logic       terminal;
    logic [7:0] dim_now, dim_wr, wr_month;
    logic [15:0] wr_year;
    logic       wr_ok, hi_zero;

    assign terminal = bus.run && (pre_q == PRE_LAST);

    // Carry path: length of the current month.
    rtc_days_in_month u_dim_carry (
        .month_bcd_i (month_q),
        .leap_i      (is_leap(year_q)),
        .last_day_o  (dim_now)
    );

    // Write path: length of the month as it will be after this write, so a
    // month/year write can clamp the day and a day write is validated
    // against the current month/year.
    assign wr_month = (bus.set_field == FLD_MONTH) ? bus.set_data[7:0] : month_q;
    assign wr_year  = (bus.set_field == FLD_YEAR)  ? bus.set_data      : year_q;

    rtc_days_in_month u_dim_wr (
        .month_bcd_i (wr_month),
        .leap_i      (is_leap(wr_year)),
        .last_day_o  (dim_wr)
    );

    always_comb begin
        hi_zero = (bus.set_data[15:8] == 8'h00);
        wr_ok   = nibbles_ok(bus.set_data);
        case (bus.set_field)
            FLD_SEC, FLD_MIN: wr_ok = wr_ok && hi_zero && (bus.set_data[7:0] <= BCD_59);
            FLD_HOUR:         wr_ok = wr_ok && hi_zero && (bus.set_data[7:0] <= BCD_23);
            FLD_DAY:          wr_ok = wr_ok && hi_zero && (bus.set_data[7:0] != 8'h00) &&
                                      (bus.set_data[7:0] <= dim_wr);
            FLD_MONTH:        wr_ok = wr_ok && hi_zero && (bus.set_data[7:0] != 8'h00) &&
                                      (bus.set_data[7:0] <= BCD_12);
            FLD_YEAR:         wr_ok = wr_ok;
            FLD_WDAY:         wr_ok = (bus.set_data <= 16'd6);
            default:          wr_ok = 1'b0;
        endcase
    end

    // Next state. Any write request pre-empts a coincident tick: the tick is
    // dropped, though the prescaler still wraps as usual.
    always_comb begin
        pre_d     = pre_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        wday_d    = wday_q;
        set_err_d = 1'b0;
        tick_d    = 1'b0;

        if (bus.run) pre_d = terminal ? '0 : pre_q + 1'b1;

        if (bus.set_valid) begin
            if (wr_ok) begin
                case (bus.set_field)
                    FLD_SEC: begin
                        sec_d = bus.set_data[7:0];
                        pre_d = '0;
                    end
                    FLD_MIN:   min_d  = bus.set_data[7:0];
                    FLD_HOUR:  hour_d = bus.set_data[7:0];
                    FLD_DAY:   day_d  = bus.set_data[7:0];
                    FLD_MONTH: begin
                        month_d = bus.set_data[7:0];
                        if (day_q > dim_wr) day_d = dim_wr;
                    end
                    FLD_YEAR: begin
                        year_d = bus.set_data;
                        if (day_q > dim_wr) day_d = dim_wr;
                    end
                    FLD_WDAY:  wday_d = bus.set_data[2:0];
                    default:   ;
                endcase
            end else begin
                set_err_d = 1'b1;
            end
        end else if (terminal) begin
            tick_d = 1'b1;
            sec_d  = (sec_q == BCD_59) ? 8'h00 : bcd_inc8(sec_q);
            if (sec_q == BCD_59) begin
                min_d = (min_q == BCD_59) ? 8'h00 : bcd_inc8(min_q);
                if (min_q == BCD_59) begin
                    hour_d = (hour_q == BCD_23) ? 8'h00 : bcd_inc8(hour_q);
                    if (hour_q == BCD_23) begin
                        wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
                        if (day_q >= dim_now) begin
                            day_d = 8'h01;
                            if (month_q == BCD_12) begin
                                month_d = 8'h01;
                                year_d  = bcd_inc16(year_q);
                            end else begin
                                month_d = bcd_inc8(month_q);
                            end
                        end else begin
                            day_d = bcd_inc8(day_q);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q     <= '0;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_q    <= 8'h00;
            day_q     <= 8'h01;
            month_q   <= 8'h01;
            year_q    <= RESET_YEAR;
            wday_q    <= RESET_WEEKDAY;
            set_err_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            wday_q    <= wday_d;
            set_err_q <= set_err_d;
            tick_q    <= tick_d;
        end
    end

    // The cycle showing a freshly ticked hh:mm:00 is the compare cycle, so
    // pending appears one cycle after the time outputs. Field writes never
    // raise tick_q and therefore never trigger an alarm.
    logic minute_strobe;
    assign minute_strobe = tick_q && (sec_q == 8'h00);

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alm
        logic       en_q;
        logic [7:0] hh_q, mm_q;
        logic       pend_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                en_q   <= 1'b0;
                hh_q   <= 8'h00;
                mm_q   <= 8'h00;
                pend_q <= 1'b0;
            end else begin
                // Only an exact index match writes; out-of-range indices fall through.
                if (bus.alm_wr && (bus.alm_idx == 3'(i))) begin
                    en_q <= bus.alm_data[16];
                    hh_q <= bus.alm_data[15:8];
                    mm_q <= bus.alm_data[7:0];
                end
                if (minute_strobe && en_q && (hour_q == hh_q) && (min_q == mm_q)) begin
                    pend_q <= 1'b1;
                end else if (bus.alm_ack[i]) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign bus.alm_pending[i] = pend_q;
    end

    // 12 h presentation derived from the internal 24 h hour.
    logic [7:0] hour_pres;
    logic       pm_pres;
    always_comb begin
        hour_pres = hour_q;
        pm_pres   = 1'b0;
        if (bus.hour_mode) begin
            if (hour_q == 8'h00) begin
                hour_pres = BCD_12;
            end else if (hour_q >= BCD_12) begin
                pm_pres = 1'b1;
                if (hour_q != BCD_12) hour_pres = bin2bcd8(bcd2bin8(hour_q) - 8'd12);
            end
        end
    end

    assign bus.set_err   = set_err_q;
    assign bus.tick_1hz  = tick_q;
    assign bus.sec_bcd   = sec_q;
    assign bus.min_bcd   = min_q;
    assign bus.hour_bcd  = hour_pres;
    assign bus.pm        = pm_pres;
    assign bus.day_bcd   = day_q;
    assign bus.month_bcd = month_q;
    assign bus.year_bcd  = year_q;
    assign bus.weekday   = wday_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core: self-checking bench for rtc_calendar_core with
// CLK_DIV=4 and four alarm channels.
module tb_rtc_calendar_core;
    localparam int CLK_DIV = 4;
    localparam int NA      = 4;

    localparam logic [2:0] F_SEC = 3'd0, F_MIN = 3'd1, F_HOUR = 3'd2, F_DAY = 3'd3;
    localparam logic [2:0] F_MON = 3'd4, F_YEAR = 3'd5, F_WDAY = 3'd6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    rtc_calendar_core_if #(.NUM_ALARMS(NA)) bus ();

    rtc_calendar_core #(
        .CLK_DIV       (CLK_DIV),
        .NUM_ALARMS    (NA),
        .RESET_YEAR    (16'h2000),
        .RESET_WEEKDAY (3'd6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integers) ----------------
    int m_sec, m_min, m_hour, m_day, m_mon, m_year, m_wday;

    function automatic bit leap_i(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim_i(int m, int y);
        case (m)
            2:              return leap_i(y) ? 29 : 28;
            4, 6, 9, 11:    return 30;
            default:        return 31;
        endcase
    endfunction

    function automatic logic [7:0] bcd8(int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [15:0] bcd16(int v);
        return {bcd8(v / 100), bcd8(v % 100)};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 2000; m_wday = 6;
    endtask

    task automatic model_tick();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0; m_min++;
            if (m_min == 60) begin
                m_min = 0; m_hour++;
                if (m_hour == 24) begin
                    m_hour = 0;
                    m_wday = (m_wday + 1) % 7;
                    m_day++;
                    if (m_day > dim_i(m_mon, m_year)) begin
                        m_day = 1; m_mon++;
                        if (m_mon > 12) begin
                            m_mon = 1;
                            m_year = (m_year + 1) % 10000;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk_time(input string tag);
        chk({tag, ".sec"},   bus.sec_bcd,   bcd8(m_sec));
        chk({tag, ".min"},   bus.min_bcd,   bcd8(m_min));
        chk({tag, ".hour"},  bus.hour_bcd,  bcd8(m_hour));
        chk({tag, ".day"},   bus.day_bcd,   bcd8(m_day));
        chk({tag, ".month"}, bus.month_bcd, bcd8(m_mon));
        chk({tag, ".year"},  bus.year_bcd,  bcd16(m_year));
        chk({tag, ".wday"},  bus.weekday,   m_wday);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [2:0] f, input logic [15:0] d);
        bus.set_valid = 1'b1;
        bus.set_field = f;
        bus.set_data  = d;
        step();
        bus.set_valid = 1'b0;
    endtask

    task automatic alm_write(input logic [2:0] idx, input logic [16:0] d);
        bus.alm_wr   = 1'b1;
        bus.alm_idx  = idx;
        bus.alm_data = d;
        step();
        bus.alm_wr   = 1'b0;
    endtask

    task automatic set_datetime(input int y, mo, d, h, mi, s, w);
        logic [2:0]  f[7]  = '{F_YEAR, F_MON, F_DAY, F_HOUR, F_MIN, F_SEC, F_WDAY};
        logic [15:0] v[7];
        v = '{bcd16(y), {8'h00, bcd8(mo)}, {8'h00, bcd8(d)}, {8'h00, bcd8(h)},
              {8'h00, bcd8(mi)}, {8'h00, bcd8(s)}, 16'(w)};
        for (int i = 0; i < 7; i++) begin
            do_write(f[i], v[i]);
            chk($sformatf("setdt.err%0d", i), bus.set_err, 1'b0);
        end
        m_year = y; m_mon = mo; m_day = d; m_hour = h; m_min = mi; m_sec = s; m_wday = w;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.tick_1hz !== 1'b1 && n < 12);
        chk({tag, ".tick_seen"}, bus.tick_1hz, 1'b1);
    endtask

    function automatic logic [15:0] get_field(input logic [2:0] sel);
        case (sel)
            F_SEC:   return {8'h00, bus.sec_bcd};
            F_MIN:   return {8'h00, bus.min_bcd};
            F_HOUR:  return {8'h00, bus.hour_bcd};
            F_DAY:   return {8'h00, bus.day_bcd};
            F_MON:   return {8'h00, bus.month_bcd};
            F_YEAR:  return bus.year_bcd;
            default: return {13'd0, bus.weekday};
        endcase
    endfunction

    // ---------------- vector tables ----------------
    typedef struct packed {
        logic [2:0]  fld;
        logic [15:0] data;
        logic        err;
        logic [2:0]  sel;
        logic [15:0] val;
    } wr_vec_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] exp_hh;
        logic       exp_pm;
    } h12_vec_t;

    typedef struct {
        int y, mo, d, h, mi, s, w, n;
    } scen_t;

    wr_vec_t  wv[$];
    h12_vec_t hv[$];
    scen_t    sc[$];

    // ---------------- test sequence ----------------
    initial begin
        bus.run = 1'b0; bus.hour_mode = 1'b0; bus.set_valid = 1'b0;
        bus.set_field = 3'd0; bus.set_data = 16'h0; bus.alm_wr = 1'b0;
        bus.alm_idx = 3'd0; bus.alm_data = 17'h0; bus.alm_ack = '0;

        // Starting state 2000-01-01 00:00:03 (after the prescaler test).
        wv.push_back('{F_YEAR, 16'h2023, 1'b0, F_YEAR, 16'h2023});
        wv.push_back('{F_MON,  16'h0004, 1'b0, F_MON,  16'h0004});
        wv.push_back('{F_DAY,  16'h0031, 1'b1, F_DAY,  16'h0001});
        wv.push_back('{F_DAY,  16'h0030, 1'b0, F_DAY,  16'h0030});
        wv.push_back('{F_MON,  16'h0013, 1'b1, F_MON,  16'h0004});
        wv.push_back('{F_MON,  16'h0000, 1'b1, F_MON,  16'h0004});
        wv.push_back('{F_SEC,  16'h0060, 1'b1, F_SEC,  16'h0003});
        wv.push_back('{F_SEC,  16'h005A, 1'b1, F_SEC,  16'h0003});
        wv.push_back('{F_MIN,  16'h0159, 1'b1, F_MIN,  16'h0000});
        wv.push_back('{F_HOUR, 16'h0024, 1'b1, F_HOUR, 16'h0000});
        wv.push_back('{F_HOUR, 16'h0023, 1'b0, F_HOUR, 16'h0023});
        wv.push_back('{3'd7,   16'h0001, 1'b1, F_SEC,  16'h0003});
        wv.push_back('{F_WDAY, 16'h0007, 1'b1, F_WDAY, 16'h0006});
        wv.push_back('{F_WDAY, 16'h0003, 1'b0, F_WDAY, 16'h0003});
        wv.push_back('{F_YEAR, 16'h20A4, 1'b1, F_YEAR, 16'h2023});
        wv.push_back('{F_YEAR, 16'h2024, 1'b0, F_YEAR, 16'h2024});
        wv.push_back('{F_MON,  16'h0003, 1'b0, F_DAY,  16'h0030});
        wv.push_back('{F_DAY,  16'h0031, 1'b0, F_DAY,  16'h0031});
        wv.push_back('{F_MON,  16'h0002, 1'b0, F_DAY,  16'h0029});
        wv.push_back('{F_YEAR, 16'h2023, 1'b0, F_DAY,  16'h0028});
        wv.push_back('{F_DAY,  16'h0000, 1'b1, F_DAY,  16'h0028});
        wv.push_back('{F_DAY,  16'h0029, 1'b1, F_DAY,  16'h0028});

        hv.push_back('{8'h00, 8'h12, 1'b0});
        hv.push_back('{8'h12, 8'h12, 1'b1});
        hv.push_back('{8'h13, 8'h01, 1'b1});
        hv.push_back('{8'h11, 8'h11, 1'b0});
        hv.push_back('{8'h20, 8'h08, 1'b1});
        hv.push_back('{8'h23, 8'h11, 1'b1});

        sc.push_back('{2023, 12, 31, 23, 59, 59, 0, 1});
        sc.push_back('{2024,  2, 28, 23, 59, 59, 3, 2});
        sc.push_back('{1900,  2, 28, 23, 59, 59, 3, 1});
        sc.push_back('{2000,  2, 28, 23, 59, 59, 1, 1});
        sc.push_back('{9999, 12, 31, 23, 59, 59, 5, 1});
        sc.push_back('{2024,  2, 29, 23, 59, 58, 4, 3});
        for (int i = 0; i < 8; i++) begin
            scen_t s;
            s.y  = $urandom_range(0, 9999);
            s.mo = $urandom_range(1, 12);
            s.d  = $urandom_range(0, 1) ? dim_i(s.mo, s.y) : $urandom_range(1, dim_i(s.mo, s.y));
            s.h  = $urandom_range(0, 1) ? 23 : $urandom_range(0, 23);
            s.mi = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
            s.s  = $urandom_range(55, 59);
            s.w  = $urandom_range(0, 6);
            s.n  = $urandom_range(1, 6);
            sc.push_back(s);
        end

        // Reset values
        step();
        step();
        chk("rst.sec", bus.sec_bcd, 8'h00);
        chk("rst.min", bus.min_bcd, 8'h00);
        chk("rst.hour", bus.hour_bcd, 8'h00);
        chk("rst.day", bus.day_bcd, 8'h01);
        chk("rst.month", bus.month_bcd, 8'h01);
        chk("rst.year", bus.year_bcd, 16'h2000);
        chk("rst.wday", bus.weekday, 3'd6);
        chk("rst.pend", bus.alm_pending, 4'b0000);
        chk("rst.err", bus.set_err, 1'b0);
        chk("rst.tick", bus.tick_1hz, 1'b0);
        bus.hour_mode = 1'b1;
        #1;
        chk("rst.hour12", bus.hour_bcd, 8'h12);
        chk("rst.pm", bus.pm, 1'b0);
        bus.hour_mode = 1'b0;

        // Prescaler: tick every 4th cycle
        RST = 1'b0;
        bus.run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("pre.tick%0d", i), bus.tick_1hz, (i % 4 == 0));
            chk($sformatf("pre.sec%0d", i), bus.sec_bcd, bcd8(i / 4));
        end
        bus.run = 1'b0;

        // Field-write table
        foreach (wv[i]) begin
            do_write(wv[i].fld, wv[i].data);
            chk($sformatf("wr%0d.err", i), bus.set_err, wv[i].err);
            chk($sformatf("wr%0d.val", i), get_field(wv[i].sel), wv[i].val);
            step();
            chk($sformatf("wr%0d.errpulse", i), bus.set_err, 1'b0);
        end

        // 12 h presentation table
        bus.hour_mode = 1'b1;
        foreach (hv[i]) begin
            do_write(F_HOUR, {8'h00, hv[i].hour});
            chk($sformatf("h12_%0d.hh", i), bus.hour_bcd, hv[i].exp_hh);
            chk($sformatf("h12_%0d.pm", i), bus.pm, hv[i].exp_pm);
        end
        bus.hour_mode = 1'b0;
        #1;
        chk("h24.hour", bus.hour_bcd, 8'h23);
        chk("h24.pm", bus.pm, 1'b0);

        // Calendar scenarios against the model
        foreach (sc[i]) begin
            bus.run = 1'b0;
            set_datetime(sc[i].y, sc[i].mo, sc[i].d, sc[i].h, sc[i].mi, sc[i].s, sc[i].w);
            bus.run = 1'b1;
            for (int k = 0; k < sc[i].n; k++) begin
                wait_tick($sformatf("sc%0d.%0d", i, k));
                model_tick();
                chk_time($sformatf("sc%0d.%0d", i, k));
            end
            if (i == 0) begin
                chk("newyear.day", bus.day_bcd, 8'h01);
                chk("newyear.month", bus.month_bcd, 8'h01);
                chk("newyear.year", bus.year_bcd, 16'h2024);
                chk("newyear.wday", bus.weekday, 3'd1);
            end
        end
        bus.run = 1'b0;

        // Alarms
        alm_write(3'd0, {1'b1, 8'h07, 8'h30});
        alm_write(3'd1, {1'b1, 8'h07, 8'h31});
        alm_write(3'd2, {1'b1, 8'h07, 8'h30});
        alm_write(3'd3, {1'b0, 8'h07, 8'h30});
        alm_write(3'd4, {1'b0, 8'h00, 8'h00});
        set_datetime(2024, 6, 15, 7, 29, 59, 6);
        bus.run = 1'b1;
        wait_tick("alm");
        model_tick();
        chk_time("alm");
        chk("alm.notyet", bus.alm_pending, 4'b0000);
        step();
        chk("alm.set", bus.alm_pending, 4'b0101);
        alm_write(3'd2, {1'b0, 8'h07, 8'h30});
        chk("alm.disable_keeps", bus.alm_pending, 4'b0101);
        bus.alm_ack = 4'b0001;
        step();
        bus.alm_ack = 4'b0000;
        chk("alm.ack0", bus.alm_pending, 4'b0100);
        bus.alm_ack = 4'b0100;
        step();
        bus.alm_ack = 4'b0000;
        chk("alm.ack2", bus.alm_pending, 4'b0000);
        bus.run = 1'b0;
        set_datetime(2024, 6, 15, 7, 30, 0, 6);
        step();
        step();
        chk("alm.write_no_trig", bus.alm_pending, 4'b0000);
        set_datetime(2024, 6, 15, 7, 29, 59, 6);
        bus.run = 1'b1;
        wait_tick("alm2");
        model_tick();
        bus.alm_ack = 4'b0001;
        step();
        bus.alm_ack = 4'b0000;
        chk("alm.set_beats_ack", bus.alm_pending, 4'b0001);

        // Write coincident with a tick: tick dropped, written value held
        wait_tick("coin.pre");
        model_tick();
        chk_time("coin.pre");
        step();
        step();
        step();
        do_write(F_MIN, 16'h0042);
        m_min = 42;
        chk("coin.tick", bus.tick_1hz, 1'b0);
        chk_time("coin.post");
        wait_tick("coin.next");
        model_tick();
        chk_time("coin.next");

        // Reset mid-operation
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk_time("rst2");
        chk("rst2.pend", bus.alm_pending, 4'b0000);
        chk("rst2.tick", bus.tick_1hz, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (bus.tick_1hz !== 1'b1 && n < 12);
            chk("rst2.first_tick_cycles", n, CLK_DIV);
        end
        model_tick();
        chk_time("rst2.after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
Single-clock time/date keeper replacing derived-clock ripple counters. A parametrised prescaler generates clock-enable ticks, and all BCD fields (ss, mm, hh, DD, MM, YYYY, weekday) advance synchronously on CLK. The core also provides:
- a validated field-write interface
- 12/24 h presentation
- NUM_ALARMS hh:mm alarm channels with sticky pending flags

It sits below the display/weekday-decoder logic and feeds them BCD directly.

Parameters:
CLK_DIV, 100000000, CLK cycles per second tick (>=2)
NUM_ALARMS, 4, number of alarm channels (1..8)
RESET_YEAR, 16'h2000, BCD year loaded at reset
RESET_WEEKDAY, 6, weekday at reset (0=Sunday; 2000-01-01 is Saturday)

Ports:
CLK in 1 system clock
RST in 1 reset, asynchronous, active-high
run in 1 1=time advances; 0=prescaler and counters frozen
hour_mode in 1 0=24 h, 1=12 h presentation
set_valid in 1 field-write request
set_field in 3 0 sec, 1 min, 2 hour(24h), 3 day, 4 month, 5 year, 6 weekday
set_data in 16 BCD value, right-aligned
set_err out 1 one-cycle pulse: write rejected
alm_wr in 1 alarm config write
alm_idx in 3 alarm channel index
alm_data in 17 {enable, hour_bcd[15:8] 24h, min_bcd[7:0]}
alm_ack in NUM_ALARMS per-channel pending clear
alm_pending out NUM_ALARMS sticky alarm flags
tick_1hz out 1 one-cycle pulse per accepted second tick
sec_bcd out 8, min_bcd out 8, hour_bcd out 8 (presentation form), pm out 1
day_bcd out 8, month_bcd out 8, year_bcd out 16, weekday out 3

Behaviour:
- Reset: 00:00:00, day 01, month 01, year RESET_YEAR, weekday RESET_WEEKDAY, prescaler 0, all alarms disabled at 00:00, alm_pending 0, set_err 0, tick_1hz 0, pm 0. hour_bcd resets to 8'h00 in 24 h mode, or 8'h12 if hour_mode=1.
- Prescaler: counts 0..CLK_DIV-1 while run=1. At CLK_DIV-1 it wraps to 0 and issues a tick. With run=0 it holds its value.
- Tick: all time registers update on the same edge; tick_1hz is registered high for that cycle. Outputs change on the edge following the prescaler terminal count (latency 1 cycle).
- Carry chain:
  - sec 59->00 carries to min; min 59->00 carries to hour; hour 23->00 carries to day and weekday (6->0).
  - day wraps to 01 after days-in-month (31/30; Feb 28, or 29 in a leap year) and carries to month.
  - month 12->01 carries to year; year 9999->0000.
  - Leap year: divisible by 4 and not by 100, or divisible by 400 (0000 is leap).
- Field write: accepted in the same cycle as set_valid; writes are always ready.
  - Priority: a write beats a coincident tick. That tick is discarded entirely (no field advances, no tick_1hz).
  - A write to sec also clears the prescaler.
  - Validation:
    - each nibble must be <=9
    - sec/min <=59; hour <=23
    - day 01..days-in-month(current month, current year); month 01..12
    - weekday <=6; set_field 7 is invalid
  - Invalid write: no state change; set_err=1 on the next cycle.
- Clamping: a valid write to month or year that leaves day > days-in-month clamps day to the last valid day in the same cycle (e.g. 31 Mar -> month 02 in 2023 gives 28).
- 12 h presentation: combinational from the internal 24 h value.
  - hh 00 -> 12 with pm=0; 01..11 -> pm=0; 12 -> 12 with pm=1; 13..23 -> hh-12 with pm=1.
  - In 24 h mode pm is always 0.
- Alarms:
  - alm_wr with alm_idx < NUM_ALARMS writes that channel; an out-of-range alm_idx is ignored.
  - Alarm data is not validated: out-of-range values simply never match.
  - Trigger: on a tick that produces sec=00, each enabled channel whose hh:mm equals the new hh:mm sets its pending bit. Pending is visible the cycle after the time outputs show hh:mm:00.
  - Field writes never trigger alarms.
  - alm_ack[i] clears bit i; a set in the same cycle wins.
  - Disabling a channel does not clear its pending bit.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); the first tick occurs CLK_DIV cycles after deassertion.

Decomposition:
- Shared package rtc_pkg holds:
  - field-select localparams (FLD_SEC..FLD_WDAY)
  - BCD constants (8'h59, 8'h23, 8'h12)
  - a function is_leap(bcd16)
- One sub-module, rtc_days_in_month: combinational (month_bcd, leap) -> last-day BCD. It is instantiated twice: once for the carry path and once for write validation/clamping.
- The alarm bank is a generate loop inside the core.

Test Plan:
- CLK_DIV=4, reset, run=1 for 12 cycles -> tick_1hz every 4th cycle; sec_bcd 00->01->02->03.
- Write 23:59:59 on 2023-12-31, weekday 0, then one tick -> 00:00:00 2024-01-01, weekday 1.
- Year 2024 and 1900, date 02-28 23:59:59, one tick -> 02-29 for 2024; 03-01 for 1900.
- Writes: day 31 with month 04 -> set_err pulse, day unchanged. Then 2024-03-31 write month 02 -> day_bcd 8'h29.
- Alarm 0 = {1,8'h07,8'h30}, time 07:29:59, one tick -> alm_pending[0]=1 one cycle after 07:30:00. Ack with no coincident set -> 0. Writing 07:30:00 directly -> no pending.
- hour_mode=1 with hours 00, 12, 13 -> hour_bcd 12/12/01, pm 0/1/1. Write coincident with a tick -> tick dropped, written value held.
